// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises the divided tick, debounces the start/stop and clear
// buttons, and runs an IDLE/RUNNING/PAUSED FSM that gates a 4-digit BCD mm:ss counter.
// All outputs come straight from flops.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_MIN_TENS    = 5
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic [1:0] state,
  output logic       wrap_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax     = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      MinTensMax = 4'(MAX_MIN_TENS);

  // Button index within the packed button vectors.
  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnClear = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Tick path: bit0 = s1, bit1 = s2, bit2 = s3 (history for rising-edge detect)
  // ---------------------------------------------------------------------------
  logic [2:0] tick_sync_q, tick_sync_d;
  logic       tick_evt;

  // Shift the raw tick through the synchroniser and history stage.
  always_comb begin
    tick_sync_d = {tick_sync_q[1:0], tick_in};
  end

  assign tick_evt = tick_sync_q[1] & ~tick_sync_q[2];

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchroniser followed by a stability counter per button
  // ---------------------------------------------------------------------------
  logic [1:0]           btn_raw;
  logic [1:0]           btn_s1_q, btn_s1_d;
  logic [1:0]           btn_s2_q, btn_s2_d;
  logic [1:0]           btn_db_q, btn_db_d;
  logic [1:0]           press_q, press_d;
  logic [1:0][CntW-1:0] db_cnt_q, db_cnt_d;
  logic                 start_evt;
  logic                 clear_evt;

  assign btn_raw = {btn_clear, btn_start_stop};

  // Debounce: count cycles the synced level disagrees with the accepted level; flip once the
  // disagreement has lasted DEBOUNCE_CYCLES cycles. Only a 0->1 flip produces a press.
  always_comb begin
    btn_s1_d = btn_raw;
    btn_s2_d = btn_s1_q;
    btn_db_d = btn_db_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] != btn_db_q[i]) begin
        if (db_cnt_q[i] == CntMax) begin
          btn_db_d[i] = btn_s2_q[i];
          press_d[i]  = btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign start_evt = press_q[BtnStart];
  assign clear_evt = press_q[BtnClear];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   running_q, running_d;

  // Next-state: clear beats start/stop; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start_evt) state_d = StRun;
        StRun:   if (start_evt) state_d = StPause;
        StPause: if (start_evt) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
    running_d = (state_d == StRun);
  end

  // ---------------------------------------------------------------------------
  // BCD mm:ss counter
  // ---------------------------------------------------------------------------
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       wrap_q, wrap_d;
  logic       count_en;

  // Gate on the current state so a tick on the edge that leaves RUNNING still counts and a
  // tick on the edge that enters RUNNING does not.
  assign count_en = (state_q == StRun) && tick_evt;

  // Ripple-carry BCD increment; '>=' comparisons pull any out-of-range digit back to 0.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (clear_evt) begin
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
    end else if (count_en) begin
      if (sec_ones_q < 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = '0;
        if (sec_tens_q < 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = '0;
          if (min_ones_q < 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = '0;
            if (min_tens_q < MinTensMax) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = '0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  // State registers, all cleared asynchronously by rst.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tick_sync_q <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_db_q    <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
      state_q     <= StIdle;
      running_q   <= 1'b0;
      sec_ones_q  <= '0;
      sec_tens_q  <= '0;
      min_ones_q  <= '0;
      min_tens_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      tick_sync_q <= tick_sync_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_db_q    <= btn_db_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      running_q   <= running_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      wrap_q      <= wrap_d;
    end
  end

  assign sec_ones   = sec_ones_q;
  assign sec_tens   = sec_tens_q;
  assign min_ones   = min_ones_q;
  assign min_tens   = min_tens_q;
  assign running    = running_q;
  assign state      = state_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Consumes the slow toggling output of the team's clock divider as `tick_in`, on its own domain `clk_in`.
- Synchronises and edge-detects `tick_in`, debounces two push-buttons, and runs an IDLE/RUNNING/PAUSED FSM.
- The FSM gates a 4-digit BCD mm:ss counter. Digits feed the display multiplexer downstream.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive clk_in cycles a synchronised button level must be stable before it is accepted (min 2; bench uses 4).
- MAX_MIN_TENS, 5, highest minutes-tens digit before wrap (59:59 -> 00:00 at default).

Ports:
- clk_in  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tick_in  input  1  divided clock from the clock divider; each rising edge = one count step; asynchronous to clk_in logic, must be synchronised.
- btn_start_stop  input  1  raw push-button, active-high, bouncy.
- btn_clear  input  1  raw push-button, active-high, bouncy.
- sec_ones  output  4  BCD 0-9.
- sec_tens  output  4  BCD 0-5.
- min_ones  output  4  BCD 0-9.
- min_tens  output  4  BCD 0-MAX_MIN_TENS.
- running  output  1  high in RUNNING.
- state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED (11 unused, recovers to IDLE).
- wrap_pulse  output  1  one clk_in-cycle pulse when the count wraps max -> 00:00.

Behaviour:
- Reset (async, rst=1): all digits 0, state IDLE, running 0, wrap_pulse 0, synchronisers 0, debounced levels 0, debounce counters 0. No events are generated on release.
- Tick path: 2-FF synchroniser s1, s2 plus history s3. tick_evt = s2 & ~s3.
  - First clk_in edge sampling tick_in=1 is E1; the counter updates at E3.
  - One event per tick_in rising edge; falling edges are ignored.
- Button path, per button:
  - 2-FF synchroniser, then debounce counter.
  - If the synced level differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the difference still present, the debounced level flips and the counter clears.
  - Press event = debounced 0->1, one cycle wide. Release generates no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM (events applied on the edge they are high):
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> PAUSED.
  - PAUSED: start_stop -> RUNNING.
  - Any state: clear event -> IDLE with all digits 0; clear has priority over start_stop in the same cycle.
- Counting occurs only when the state register currently holds RUNNING and tick_evt=1.
  - Tick coincident with a start_stop press that leaves RUNNING: the tick still counts.
  - Tick coincident with a press that enters RUNNING: the tick is not counted.
  - Tick coincident with clear: clear wins, digits 0.
- BCD increment (ripple carry, all in one cycle):
  - sec_ones 9 -> 0 carries to sec_tens.
  - sec_tens 5 -> 0 carries to min_ones.
  - min_ones 9 -> 0 carries to min_tens.
  - min_tens MAX_MIN_TENS -> 0 sets wrap_pulse for that one cycle, and the count continues from 00:00.
- Digits never hold non-BCD values.
- Reset asserted mid-count or mid-debounce: immediate return to the reset values above.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: hold rst 3 cycles, toggle tick_in 5 times with no buttons -> digits 00:00, state 00, running 0.
- Debounce: with DEBOUNCE_CYCLES=4, pulse btn_start_stop high for 2 cycles -> no state change. Hold it high for 6 cycles -> state 01 exactly 2+4 cycles after the first high sample. Bounce 1-0-1 on release -> no second event.
- Counting and latency: RUNNING, 12 tick_in rising edges -> 00:12. Each update lands on the 3rd clk_in edge after tick_in rises. Falling edges cause no change.
- Carry and wrap: RUNNING from 00:58, 2 ticks -> 01:00. From 59:59, 1 tick -> 00:00 with wrap_pulse high exactly 1 cycle.
- Pause/resume/clear: at 00:07 press start_stop -> PAUSED, 3 ticks leave 00:07. Press again -> 1 tick gives 00:08. Press clear -> IDLE, 00:00. Clear and start_stop events in the same cycle -> IDLE.
- Async reset mid-run: at 03:41 RUNNING, assert rst between clk_in edges -> outputs zero and IDLE immediately, before the next clk_in edge.
